pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Program counter and next-PC selection for the RV32I core; sits directly downstream of branchgen.
//  Takes branchgen's brnch flag and the EX-stage control, immediate and operands, then computes the
//  redirect target. Drives the instruction-memory fetch address.
//  Raises flush to the IF/ID and ID/EX registers on a taken redirect. Traps misaligned targets.
// PARAMETERS
//  n          32            datapath / address width
//  RESET_VEC  32'h0000_0000 PC value loaded on reset
//  TRAP_VEC   32'h0000_0100 PC value loaded on misaligned-target trap
// PORTS
//  clock       in   1  system clock, all state updates on rising edge
//  nReset      in   1  synchronous, active-low reset
//  stall       in   1  hazard stall from decode; hold PC
//  imem_ready  in   1  instruction memory accepts/returns fetch this cycle
//  brnch       in   1  branch condition from branchgen (EX stage)
//  is_branch   in   1  EX instr is conditional branch
//  is_jal      in   1  EX instr is JAL
//  is_jalr     in   1  EX instr is JALR
//  ex_pc       in   n  PC of EX instr
//  ex_imm      in   n  sign-extended immediate of EX instr
//  ex_rs1      in   n  rs1 operand of EX instr (JALR base)
//  pc          out  n  current fetch address (registered)
//  pc_plus4    out  n  pc + 4, mod 2^n (combinational)
//  imem_req    out  1  fetch request
//  if_valid    out  1  fetched instr this cycle is valid for IF/ID
//  flush       out  1  squash IF/ID and ID/EX (combinational)
//  misalign    out  1  one-cycle trap pulse (registered)
//  mepc        out  n  ex_pc of the instr that caused the trap (registered)
// BEHAVIOUR
//  Reset: nReset low at a clock edge -> state BOOT, pc=RESET_VEC, mepc=0, pend=0.
//   Reset overrides all other inputs, including mid-WAIT and mid-TRAP.
//  Target and redirect:
//   redirect = (is_branch & brnch) | is_jal | is_jalr
//   target   = is_jalr ? ((ex_rs1 + ex_imm) & ~1) : (ex_pc + ex_imm)
//   JALR has priority if multiple is_* are set. All sums wrap mod 2^n.
//   bad      = redirect & (target[1:0] != 2'b00)
//  BOOT: imem_req=0, if_valid=0, flush=0, misalign=0; next state RUN; pc unchanged.
//  RUN: imem_req=1; flush = redirect; if_valid = imem_ready & ~stall & ~redirect. Priority, high first:
//   1 bad: pc<=TRAP_VEC, mepc<=ex_pc -> TRAP.
//   2 redirect & imem_ready: pc<=target; stay RUN.
//   3 redirect & ~imem_ready: pend<=target, pc held -> WAIT.
//   4 stall | ~imem_ready: hold pc.
//   5 else: pc<=pc_plus4 (0xFFFF_FFFC wraps to 0).
//   Redirect beats stall: stall is ignored in a redirect cycle.
//  WAIT: imem_req=1, if_valid=0, flush=0; redirect/stall inputs ignored (pipeline already flushed).
//   imem_ready=1 -> pc<=pend, go to RUN.
//  TRAP: misalign=1, imem_req=0, if_valid=0, flush=0; inputs ignored; next state RUN; pc stays TRAP_VEC.
//  Latency: a redirect seen in cycle t gives the target on pc at t+1, if imem_ready=1 at t.
//   misalign is high in cycle t+1 only.
// TESTING
//  1 Reset: nReset=0 for 2 cycles -> pc=0, imem_req=0.
//    Release with imem_ready=1 -> one BOOT cycle, then pc 0,4,8,C on successive cycles.
//  2 Taken beq: ex_pc=0x10, ex_imm=0x20, is_branch=1, brnch=1 -> flush=1, if_valid=0 that cycle; next pc=0x30.
//  3 Not-taken: is_branch=1, brnch=0, pc=0x30 -> flush=0; next pc=0x34.
//    With stall=1 instead -> pc held at 0x30.
//  4 JALR: ex_rs1=0x101, ex_imm=0x4 -> next pc=0x104 (bit0 cleared), flush=1.
//  5 Misalign: is_jal=1, ex_pc=0x40, ex_imm=0x2 -> next cycle pc=0x100, misalign=1, mepc=0x40.
//    misalign=0 the cycle after.
//  6 Redirect with imem_ready=0, target 0x80 -> WAIT, pc held for 3 cycles, if_valid=0.
//    imem_ready=1 -> pc=0x80. Separately, pc=0xFFFF_FFFC advances to 0x0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-unit bus bundle.
// master = pc_fetch (EX control in, fetch/flush/trap out); slave = pipeline side.
interface pc_fetch_if #(
   parameter int n = 32
);
   logic         stall;
   logic         imem_ready;
   logic         brnch;
   logic         is_branch;
   logic         is_jal;
   logic         is_jalr;
   logic [n-1:0] ex_pc;
   logic [n-1:0] ex_imm;
   logic [n-1:0] ex_rs1;
   logic [n-1:0] pc;
   logic [n-1:0] pc_plus4;
   logic         imem_req;
   logic         if_valid;
   logic         flush;
   logic         misalign;
   logic [n-1:0] mepc;

   modport master (
      input  stall, imem_ready, brnch,
      input  is_branch, is_jal, is_jalr,
      input  ex_pc, ex_imm, ex_rs1,
      output pc, pc_plus4, imem_req,
      output if_valid, flush, misalign, mepc
   );

   modport slave (
      output stall, imem_ready, brnch,
      output is_branch, is_jal, is_jalr,
      output ex_pc, ex_imm, ex_rs1,
      input  pc, pc_plus4, imem_req,
      input  if_valid, flush, misalign, mepc
   );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter, next-PC select, redirect flush, misalign trap.
// Ports: clock, nReset (sync, active-low), bus (pc_fetch_if.master).
module pc_fetch #(
   parameter int         n         = 32,
   parameter logic [n-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [n-1:0] TRAP_VEC  = 32'h0000_0100
) (
   input logic       clock,
   input logic       nReset,
   pc_fetch_if.master bus
);
   typedef enum logic [1:0] {
      S_BOOT, S_RUN, S_WAIT, S_TRAP
   } state_t;

   state_t       state;
   logic [n-1:0] pc_q;
   logic [n-1:0] pend_q;
   logic [n-1:0] mepc_q;
   logic         req_q;
   logic         mis_q;

   logic         redirect;
   logic         bad;
   logic [n-1:0] sum;
   logic [n-1:0] target;
   logic [n-1:0] pc_p4;
   logic         run;

   always_comb begin
      redirect = (bus.is_branch & bus.brnch)
               | bus.is_jal | bus.is_jalr;
      sum      = bus.is_jalr ? (bus.ex_rs1 + bus.ex_imm)
                             : (bus.ex_pc + bus.ex_imm);
      // JALR clears bit 0 of its sum
      target   = bus.is_jalr ? {sum[n-1:1], 1'b0} : sum;
      bad      = redirect & (target[1:0] != 2'b00);
      pc_p4    = pc_q + n'(4);
      run      = (state == S_RUN);
   end

   assign bus.pc       = pc_q;
   assign bus.pc_plus4 = pc_p4;
   assign bus.imem_req = req_q;
   assign bus.misalign = mis_q;
   assign bus.mepc     = mepc_q;
   assign bus.flush    = run & redirect;
   assign bus.if_valid = run & bus.imem_ready
                       & ~bus.stall & ~redirect;

   always_ff @(posedge clock) begin
      if (!nReset) begin
         state  <= S_BOOT;
         pc_q   <= RESET_VEC;
         pend_q <= '0;
         mepc_q <= '0;
         req_q  <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         mis_q <= 1'b0;
         unique case (state)
            S_BOOT: begin
               state <= S_RUN;
               req_q <= 1'b1;
            end
            S_RUN: begin
               if (bad) begin
                  pc_q   <= TRAP_VEC;
                  mepc_q <= bus.ex_pc;
                  mis_q  <= 1'b1;
                  req_q  <= 1'b0;
                  state  <= S_TRAP;
               end else if (redirect & bus.imem_ready) begin
                  pc_q <= target;
               end else if (redirect) begin
                  // memory busy: park target until it accepts
                  pend_q <= target;
                  state  <= S_WAIT;
               end else if (!bus.stall && bus.imem_ready) begin
                  pc_q <= pc_p4;
               end
            end
            S_WAIT: begin
               if (bus.imem_ready) begin
                  pc_q  <= pend_q;
                  state <= S_RUN;
               end
            end
            S_TRAP: begin
               state <= S_RUN;
               req_q <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed vector bench for pc_fetch.
// Table of RUN-state vectors plus hand sequences for trap/wait/reset/wrap.
module tb_pc_fetch;
   logic clock;
   logic nReset;
   int   errors = 0;
   int   checks = 0;

   pc_fetch_if #(.n(32)) bus ();

   pc_fetch #(
      .n(32),
      .RESET_VEC(32'h0000_0000),
      .TRAP_VEC(32'h0000_0100)
   ) dut (
      .clock(clock),
      .nReset(nReset),
      .bus(bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       nm;
      logic        st;
      logic        rdy;
      logic        br;
      logic        isb;
      logic        isj;
      logic        isjr;
      logic [31:0] epc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        eflush;
      logic        evalid;
      logic [31:0] enext;
   } vec_t;

   vec_t v[10];

   task automatic chk(input string nm,
                      input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   task automatic set_in(input logic st, rdy, br,
                         input logic isb, isj, isjr,
                         input logic [31:0] epc, imm, rs1);
      bus.stall      = st;
      bus.imem_ready = rdy;
      bus.brnch      = br;
      bus.is_branch  = isb;
      bus.is_jal     = isj;
      bus.is_jalr    = isjr;
      bus.ex_pc      = epc;
      bus.ex_imm     = imm;
      bus.ex_rs1     = rs1;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h0, 32'h0, 32'h0);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      v[0] = '{"beq_taken", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
               32'h10, 32'h20, 32'h0, 1'b1, 1'b0, 32'h30};
      v[1] = '{"beq_not", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
               32'h10, 32'h20, 32'h0, 1'b0, 1'b1, 32'h34};
      v[2] = '{"stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h34};
      v[3] = '{"not_ready", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h34};
      v[4] = '{"jal_over_stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               32'h34, 32'h10, 32'h0, 1'b1, 1'b0, 32'h44};
      v[5] = '{"jalr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
               32'h0, 32'h4, 32'h101, 1'b1, 1'b0, 32'h104};
      v[6] = '{"jalr_prio", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
               32'h200, 32'h8, 32'h300, 1'b1, 1'b0, 32'h308};
      v[7] = '{"jalr_neg", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
               32'h0, 32'hFFFF_FFF1, 32'h1000, 1'b1, 1'b0, 32'hFF0};
      v[8] = '{"advance", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFF4};
      v[9] = '{"brnch_nobr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h40, 32'h0, 1'b0, 1'b1, 32'hFF8};

      // reset and boot
      nReset = 1'b0;
      idle();
      cyc();
      cyc();
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_req", 32'(bus.imem_req), 32'h0);
      chk("rst_mis", 32'(bus.misalign), 32'h0);
      chk("rst_mepc", bus.mepc, 32'h0);
      nReset = 1'b1;
      #2;
      chk("boot_ifv", 32'(bus.if_valid), 32'h0);
      cyc();
      chk("boot_pc", bus.pc, 32'h0);
      chk("run_req", 32'(bus.imem_req), 32'h1);
      cyc();
      chk("seq_4", bus.pc, 32'h4);
      cyc();
      chk("seq_8", bus.pc, 32'h8);
      cyc();
      chk("seq_c", bus.pc, 32'hC);

      // table of RUN-state vectors from pc=0xC
      for (int i = 0; i < 10; i++) begin
         set_in(v[i].st, v[i].rdy, v[i].br,
                v[i].isb, v[i].isj, v[i].isjr,
                v[i].epc, v[i].imm, v[i].rs1);
         #2;
         chk({v[i].nm, "_flush"}, 32'(bus.flush),
             32'(v[i].eflush));
         chk({v[i].nm, "_ifv"}, 32'(bus.if_valid),
             32'(v[i].evalid));
         cyc();
         chk({v[i].nm, "_pc"}, bus.pc, v[i].enext);
         chk({v[i].nm, "_mis"}, 32'(bus.misalign), 32'h0);
      end

      // misaligned jal trap
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
             32'h40, 32'h2, 32'h0);
      #2;
      chk("mis_flush", 32'(bus.flush), 32'h1);
      cyc();
      chk("trap_pc", bus.pc, 32'h100);
      chk("trap_mis", 32'(bus.misalign), 32'h1);
      chk("trap_mepc", bus.mepc, 32'h40);
      chk("trap_req", 32'(bus.imem_req), 32'h0);
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
             32'h0, 32'h80, 32'h0);
      #2;
      chk("trap_flush", 32'(bus.flush), 32'h0);
      chk("trap_ifv", 32'(bus.if_valid), 32'h0);
      cyc();
      chk("post_mis", 32'(bus.misalign), 32'h0);
      chk("post_pc", bus.pc, 32'h100);
      idle();
      cyc();
      chk("post_adv", bus.pc, 32'h104);

      // redirect while memory busy -> WAIT
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
             32'h70, 32'h10, 32'h0);
      #2;
      chk("w_flush", 32'(bus.flush), 32'h1);
      chk("w_ifv", 32'(bus.if_valid), 32'h0);
      cyc();
      chk("w_hold0", bus.pc, 32'h104);
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                32'h0, 32'h200, 32'h0);
         #2;
         chk("w_noflush", 32'(bus.flush), 32'h0);
         chk("w_ifv_k", 32'(bus.if_valid), 32'h0);
         chk("w_req", 32'(bus.imem_req), 32'h1);
         cyc();
         chk("w_hold", bus.pc, 32'h104);
      end
      idle();
      #2;
      chk("w_rdy_ifv", 32'(bus.if_valid), 32'h0);
      cyc();
      chk("w_target", bus.pc, 32'h80);
      cyc();
      chk("w_after", bus.pc, 32'h84);

      // wrap-around
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
             32'hFFFF_FFF0, 32'hC, 32'h0);
      cyc();
      chk("wrap_set", bus.pc, 32'hFFFF_FFFC);
      idle();
      #2;
      chk("wrap_p4", bus.pc_plus4, 32'h0);
      cyc();
      chk("wrap_pc", bus.pc, 32'h0);
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
             32'hFFFF_FFF0, 32'h20, 32'h0);
      cyc();
      chk("wrap_tgt", bus.pc, 32'h10);

      // reset during WAIT
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
             32'h0, 32'h80, 32'h0);
      cyc();
      nReset = 1'b0;
      idle();
      cyc();
      chk("rw_pc", bus.pc, 32'h0);
      chk("rw_req", 32'(bus.imem_req), 32'h0);
      chk("rw_mepc", bus.mepc, 32'h0);
      nReset = 1'b1;
      cyc();
      chk("rw_boot", bus.pc, 32'h0);
      cyc();
      chk("rw_adv", bus.pc, 32'h4);

      // reset during TRAP
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
             32'h40, 32'h2, 32'h0);
      cyc();
      chk("rt_mis", 32'(bus.misalign), 32'h1);
      nReset = 1'b0;
      idle();
      cyc();
      chk("rt_mis0", 32'(bus.misalign), 32'h0);
      chk("rt_pc", bus.pc, 32'h0);
      nReset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
